// File: rtl/usb_uart_cmd_pkg.sv
// Shared types and character constants for the usb_uart command line receiver.
package usb_uart_cmd_pkg;

    typedef enum logic [1:0] {
        READ = 2'd0,
        GAP  = 2'd1,
        EXEC = 2'd2
    } state_t;

    localparam int MAX_LINE_DEFAULT = 8;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_W  = 8'h57;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_1  = 8'h31;

    function automatic logic is_term(input logic [7:0] ch);
        return (ch == ASCII_LF) || (ch == ASCII_CR);
    endfunction

endpackage

// File: rtl/ascii_hex_decode.sv
// Maps one ASCII character to a hex nibble; valid is low for non-hex characters.
module ascii_hex_decode (
    input  logic [7:0] ch,
    output logic       valid,
    output logic [3:0] nibble
);

    always_comb begin
        valid  = 1'b1;
        nibble = 4'd0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            nibble = ch[3:0];
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            // 'A'/'a' carry 1 in their low nibble, so +9 lands on 10
            nibble = ch[3:0] + 4'd9;
        end else begin
            valid = 1'b0;
        end
    end

endmodule

// File: rtl/usb_uart_cmd_rx.sv
// Line-oriented command receiver on the usb_uart read port: "L0"/"L1" drive led,
// "Whh" loads reg_out; anything else is counted as a rejected line.
module usb_uart_cmd_rx
    import usb_uart_cmd_pkg::*;
#(
    parameter int   MAX_LINE  = MAX_LINE_DEFAULT,
    parameter logic LED_RESET = 1'b0
) (
    input  logic       clk_48mhz,
    input  logic       resetn,
    output logic       uart_re,
    input  logic [7:0] uart_do,
    input  logic       uart_wait,
    output logic       led,
    output logic [7:0] reg_out,
    output logic       reg_stb,
    output logic       cmd_err,
    output logic [7:0] err_count,
    output state_t     dbg_state
);

    localparam int ARGS = MAX_LINE - 1;
    localparam int CW   = $clog2(MAX_LINE + 1);

    // Handshake: a byte moves when uart_re=1 and uart_wait=0 in the same cycle,
    // uart_do is sampled on that cycle; uart_re is simply "state is READ".
    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   count;
    logic            overflow;
    logic [7:0]      cmd_ch;
    logic [7:0]      args [ARGS];

    logic            accept;
    logic            exec_fire;
    logic            line_empty;
    logic [7:0]      cmd_up;
    logic            hex0_valid;
    logic            hex1_valid;
    logic [3:0]      hex0_nib;
    logic [3:0]      hex1_nib;
    logic            led_ok;
    logic            w_ok;
    logic [7:0]      w_value;

    ascii_hex_decode u_hex0 (.ch(args[0]), .valid(hex0_valid), .nibble(hex0_nib));
    ascii_hex_decode u_hex1 (.ch(args[1]), .valid(hex1_valid), .nibble(hex1_nib));

    always_ff @(posedge clk_48mhz) begin
        if (!resetn) begin
            state <= GAP;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        uart_re    = 1'b0;
        case (state)
            READ: begin
                uart_re = 1'b1;
                if (!uart_wait) begin
                    next_state = is_term(uart_do) ? EXEC : GAP;
                end
            end
            GAP:     next_state = READ;
            EXEC:    next_state = READ;
            default: next_state = GAP;
        endcase
    end

    assign dbg_state  = state;
    assign accept     = (state == READ) && !uart_wait;
    assign exec_fire  = accept && is_term(uart_do);
    assign line_empty = (count == '0) && !overflow;
    // Clearing bit 5 folds lower-case letters onto upper case
    assign cmd_up     = cmd_ch & 8'hDF;
    assign led_ok     = !overflow && (count == CW'(2)) && (cmd_up == ASCII_L) &&
                        ((args[0] == ASCII_0) || (args[0] == ASCII_1));
    assign w_ok       = !overflow && (count == CW'(3)) && (cmd_up == ASCII_W) &&
                        hex0_valid && hex1_valid;
    assign w_value    = {hex0_nib, hex1_nib};

    // The command is judged while the terminator is accepted, so its registered
    // effect is visible throughout the following EXEC cycle.
    always_ff @(posedge clk_48mhz) begin
        if (!resetn) begin
            led       <= LED_RESET;
            reg_out   <= 8'd0;
            reg_stb   <= 1'b0;
            cmd_err   <= 1'b0;
            err_count <= 8'd0;
            count     <= '0;
            overflow  <= 1'b0;
            cmd_ch    <= 8'd0;
            for (int i = 0; i < ARGS; i++) args[i] <= 8'd0;
        end else begin
            reg_stb <= 1'b0;
            cmd_err <= 1'b0;

            if (exec_fire && !line_empty) begin
                if (led_ok) begin
                    led <= args[0][0];
                end else if (w_ok) begin
                    reg_out <= w_value;
                    reg_stb <= 1'b1;
                end else begin
                    cmd_err <= 1'b1;
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                end
            end

            if (accept && !is_term(uart_do)) begin
                if (count == '0) cmd_ch <= uart_do;
                for (int i = 0; i < ARGS; i++) begin
                    if (count == CW'(i + 1)) args[i] <= uart_do;
                end
                // Count parks at MAX_LINE; later characters only raise overflow
                if (count == CW'(MAX_LINE)) overflow <= 1'b1;
                else                        count    <= count + 1'b1;
            end

            if (state == EXEC) begin
                count    <= '0;
                overflow <= 1'b0;
                cmd_ch   <= 8'd0;
                for (int i = 0; i < ARGS; i++) args[i] <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_usb_uart_cmd_rx.sv
// Bench for usb_uart_cmd_rx: a usb_uart read-port driver, a whole-line reference
// model, a reg_stb scoreboard and one task per scenario.
module tb_usb_uart_cmd_rx;
    import usb_uart_cmd_pkg::*;

    localparam int MAX_LINE = 8;
    localparam int K_NONE = 0, K_LED = 1, K_REG = 2, K_ERR = 3;

    typedef logic [7:0] byte_q_t[$];

    logic       clk_48mhz = 1'b0;
    logic       resetn    = 1'b0;
    logic       uart_re;
    logic [7:0] uart_do   = 8'h00;
    logic       uart_wait = 1'b1;
    logic       led;
    logic [7:0] reg_out;
    logic       reg_stb;
    logic       cmd_err;
    logic [7:0] err_count;
    state_t     dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int stb_seen     = 0;
    int err_seen     = 0;

    logic       m_led = 1'b0;
    logic [7:0] m_reg = 8'd0;
    logic [7:0] m_err = 8'd0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    usb_uart_cmd_rx #(.MAX_LINE(MAX_LINE), .LED_RESET(1'b0)) dut (
        .clk_48mhz (clk_48mhz),
        .resetn    (resetn),
        .uart_re   (uart_re),
        .uart_do   (uart_do),
        .uart_wait (uart_wait),
        .led       (led),
        .reg_out   (reg_out),
        .reg_stb   (reg_stb),
        .cmd_err   (cmd_err),
        .err_count (err_count),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / timeout ----------------
    always #10 clk_48mhz = ~clk_48mhz;

    initial begin
        #4000000;
        $display("FAIL timeout: simulation did not finish, run=%0d failed=%0d", tests_run, tests_failed);
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_48mhz) begin
        if (reg_stb === 1'b1) begin
            stb_seen++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_reg_stb: unexpected reg_stb, reg_out=%02h", reg_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (reg_out !== mon_exp) begin
                    tests_failed++;
                    $display("FAIL sb_reg_out: got %02h expected %02h", reg_out, mon_exp);
                end
            end
        end
        if (cmd_err === 1'b1) err_seen++;
    end

    // ---------------- reference model ----------------
    function automatic int hexv(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - int'(8'h30);
        if (c >= "a" && c <= "f") return int'(c) - int'(8'h61) + 10;
        if (c >= "A" && c <= "F") return int'(c) - int'(8'h41) + 10;
        return -1;
    endfunction

    function automatic void model_line(input byte_q_t q, output int kind, output logic [7:0] val);
        int n;
        n    = q.size();
        kind = K_ERR;
        val  = 8'd0;
        if (n == 0) begin
            kind = K_NONE;
        end else if (n <= MAX_LINE) begin
            if ((q[0] == "L" || q[0] == "l") && n == 2 && (q[1] == "0" || q[1] == "1")) begin
                kind = K_LED;
                val  = (q[1] == "1") ? 8'd1 : 8'd0;
            end else if ((q[0] == "W" || q[0] == "w") && n == 3 && hexv(q[1]) >= 0 && hexv(q[2]) >= 0) begin
                kind = K_REG;
                val  = 8'(hexv(q[1]) * 16 + hexv(q[2]));
            end
        end
    endfunction

    function automatic byte_q_t str2q(input string s);
        byte_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic byte_q_t rand_line();
        byte_q_t q;
        string   cs;
        string   hx;
        int      t;
        int      n;
        cs = "LlWw019aAfFgGxZ:";
        hx = "0123456789abcdefABCDEF";
        t  = $urandom_range(0, 3);
        if (t == 0) begin
            q.push_back(($urandom_range(0, 1) == 1) ? 8'h4C : 8'h6C);
            q.push_back(($urandom_range(0, 1) == 1) ? 8'h31 : 8'h30);
        end else if (t == 1) begin
            q.push_back(($urandom_range(0, 1) == 1) ? 8'h57 : 8'h77);
            q.push_back(hx[$urandom_range(0, hx.len() - 1)]);
            q.push_back(hx[$urandom_range(0, hx.len() - 1)]);
        end else begin
            n = $urandom_range(0, 11);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 9) == 0) q.push_back(8'h00);
                else                           q.push_back(cs[$urandom_range(0, cs.len() - 1)]);
            end
        end
        return q;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input int max_wait);
        bit done;
        done = 1'b0;
        repeat ($urandom_range(0, max_wait)) @(negedge clk_48mhz);
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk_48mhz);
            uart_do   = b;
            uart_wait = 1'b0;
            if (uart_re === 1'b1) begin
                @(posedge clk_48mhz);
                #1;
                uart_wait = 1'b1;
                done      = 1'b1;
            end
        end
        tests_run++;
        if (!done) begin
            tests_failed++;
            uart_wait = 1'b1;
            $display("FAIL handshake: byte %02h not accepted, uart_re=%b required 1 within 100 cycles", b, uart_re);
        end
    endtask

    task automatic send_line(input byte_q_t q, input logic [7:0] term, input int max_wait);
        int         kind;
        logic [7:0] val;
        int         stb0;
        int         err0;
        int         exp_stb;
        int         exp_err;
        model_line(q, kind, val);
        stb0 = stb_seen;
        err0 = err_seen;
        foreach (q[i]) send_byte(q[i], max_wait);
        if (kind == K_REG) exp_q.push_back(val);
        send_byte(term, max_wait);
        if (kind == K_LED) m_led = val[0];
        if (kind == K_REG) m_reg = val;
        if (kind == K_ERR && m_err != 8'hFF) m_err = m_err + 8'd1;
        exp_stb = (kind == K_REG) ? 1 : 0;
        exp_err = (kind == K_ERR) ? 1 : 0;
        // one cycle after the terminator was accepted
        tests_run++;
        if (uart_re !== 1'b0 || reg_stb !== 1'(exp_stb) || cmd_err !== 1'(exp_err)) begin
            tests_failed++;
            $display("FAIL exec_pulses: uart_re=%b reg_stb=%b cmd_err=%b required 0 %0d %0d (line len %0d)",
                     uart_re, reg_stb, cmd_err, exp_stb, exp_err, q.size());
        end
        tests_run++;
        if (led !== m_led || reg_out !== m_reg || err_count !== m_err) begin
            tests_failed++;
            $display("FAIL exec_state: led=%b reg_out=%02h err_count=%0d required %b %02h %0d",
                     led, reg_out, err_count, m_led, m_reg, m_err);
        end
        @(negedge clk_48mhz);
        @(negedge clk_48mhz);
        #1;
        tests_run++;
        if (reg_stb !== 1'b0 || cmd_err !== 1'b0 ||
            stb_seen - stb0 != exp_stb || err_seen - err0 != exp_err) begin
            tests_failed++;
            $display("FAIL pulse_width: reg_stb=%b cmd_err=%b stb_pulses=%0d err_pulses=%0d required 0 0 %0d %0d",
                     reg_stb, cmd_err, stb_seen - stb0, err_seen - err0, exp_stb, exp_err);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn    = 1'b0;
        uart_wait = 1'b1;
        repeat (3) @(posedge clk_48mhz);
        @(negedge clk_48mhz);
        tests_run++;
        if (uart_re !== 1'b0 || reg_stb !== 1'b0 || cmd_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: uart_re=%b reg_stb=%b cmd_err=%b required 0 0 0", uart_re, reg_stb, cmd_err);
        end
        tests_run++;
        if (led !== 1'b0 || reg_out !== 8'd0 || err_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_data: led=%b reg_out=%02h err_count=%0d required 0 00 0", led, reg_out, err_count);
        end
        tests_run++;
        if (dbg_state !== GAP) begin
            tests_failed++;
            $display("FAIL reset_state: state=%0d required %0d", dbg_state, GAP);
        end
        resetn = 1'b1;
        #1;
        tests_run++;
        if (uart_re !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_re: uart_re=%b required 0", uart_re);
        end
        @(negedge clk_48mhz);
        tests_run++;
        if (uart_re !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_first_re: uart_re=%b required 1", uart_re);
        end
        m_led = 1'b0;
        m_reg = 8'd0;
        m_err = 8'd0;
    endtask

    task automatic test_write();
        send_line(str2q("W3F"), ASCII_LF, 0);
        tests_run++;
        if (reg_out !== 8'h3F) begin
            tests_failed++;
            $display("FAIL write_3f: reg_out=%02h required 3f", reg_out);
        end
        send_line(str2q("wa7"), ASCII_CR, 2);
    endtask

    task automatic test_led();
        byte_q_t empty;
        send_line(str2q("l1"), ASCII_CR, 1);
        tests_run++;
        if (led !== 1'b1) begin
            tests_failed++;
            $display("FAIL led_on: led=%b required 1", led);
        end
        send_line(empty, ASCII_LF, 1);
        send_line(str2q("L0"), ASCII_LF, 1);
        tests_run++;
        if (led !== 1'b0) begin
            tests_failed++;
            $display("FAIL led_off: led=%b required 0", led);
        end
    endtask

    task automatic test_errors();
        int err0;
        err0 = err_seen;
        send_line(str2q("WG1"), ASCII_LF, 1);
        send_line(str2q("X"), ASCII_LF, 1);
        send_line(str2q("L2"), ASCII_LF, 1);
        send_line(str2q("W123"), ASCII_LF, 1);
        tests_run++;
        if (err_count !== 8'd4 || err_seen - err0 != 4 || reg_out !== 8'hA7 || led !== 1'b0) begin
            tests_failed++;
            $display("FAIL errors_four: err_count=%0d pulses=%0d reg_out=%02h led=%b required 4 4 a7 0",
                     err_count, err_seen - err0, reg_out, led);
        end
    endtask

    task automatic test_overflow();
        byte_q_t q;
        byte_q_t nul_q;
        for (int i = 0; i < 12; i++) q.push_back(8'h41);
        send_line(q, ASCII_LF, 0);
        send_line(str2q("W05"), ASCII_LF, 0);
        tests_run++;
        if (reg_out !== 8'h05) begin
            tests_failed++;
            $display("FAIL overflow_recover: reg_out=%02h required 05", reg_out);
        end
        // exactly MAX_LINE characters, then MAX_LINE+1, then NUL as a character
        send_line(str2q("L0000000"), ASCII_LF, 0);
        send_line(str2q("W00000000"), ASCII_CR, 0);
        nul_q.push_back(8'h4C);
        nul_q.push_back(8'h00);
        send_line(nul_q, ASCII_LF, 0);
        nul_q.delete();
        nul_q.push_back(8'h00);
        send_line(nul_q, ASCII_LF, 0);
    endtask

    task automatic test_wait_hold();
        int bad_re;
        int stb0;
        int err0;
        bad_re = 0;
        stb0   = stb_seen;
        err0   = err_seen;
        @(negedge clk_48mhz);
        uart_do   = 8'h58;
        uart_wait = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_48mhz);
            if (uart_re !== 1'b1) bad_re++;
        end
        tests_run++;
        if (bad_re != 0 || stb_seen != stb0 || err_seen != err0) begin
            tests_failed++;
            $display("FAIL wait_hold: cycles with uart_re low=%0d pulses=%0d required 0 0",
                     bad_re, (stb_seen - stb0) + (err_seen - err0));
        end
        // a held 'X' that leaked in would turn this into a rejected line
        send_line(str2q("L1"), ASCII_LF, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            send_line(rand_line(), ($urandom_range(0, 1) == 1) ? ASCII_CR : ASCII_LF, 2);
        end
    endtask

    task automatic test_reset_mid();
        byte_q_t empty;
        int      stb0;
        int      err0;
        send_byte(8'h57, 0);
        send_byte(8'h31, 0);
        @(negedge clk_48mhz);
        @(negedge clk_48mhz);
        stb0      = stb_seen;
        err0      = err_seen;
        uart_do   = ASCII_LF;
        uart_wait = 1'b0;
        resetn    = 1'b0;
        @(posedge clk_48mhz);
        #1;
        tests_run++;
        if (uart_re !== 1'b0 || reg_stb !== 1'b0 || cmd_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_ctrl: uart_re=%b reg_stb=%b cmd_err=%b required 0 0 0", uart_re, reg_stb, cmd_err);
        end
        tests_run++;
        if (err_count !== 8'd0 || reg_out !== 8'd0 || led !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_data: err_count=%0d reg_out=%02h led=%b required 0 00 0", err_count, reg_out, led);
        end
        uart_wait = 1'b1;
        @(negedge clk_48mhz);
        resetn = 1'b1;
        m_led  = 1'b0;
        m_reg  = 8'd0;
        m_err  = 8'd0;
        send_line(empty, ASCII_LF, 0);
        tests_run++;
        if (stb_seen != stb0 || err_seen != err0) begin
            tests_failed++;
            $display("FAIL midreset_pulses: stb=%0d err=%0d required 0 0", stb_seen - stb0, err_seen - err0);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 256; i++) send_line(str2q("Z"), ASCII_LF, 0);
        tests_run++;
        if (err_count !== 8'd255) begin
            tests_failed++;
            $display("FAIL err_saturate: err_count=%0d required 255", err_count);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_led();
        test_errors();
        test_overflow();
        test_wait_hold();
        test_random();
        test_reset_mid();
        test_saturate();
        repeat (3) @(negedge clk_48mhz);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain: %0d reg_stb pulses still expected, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
